// File: rtl/fifo_rd_streamer.sv
// Read-side consumer for the async FIFO: issues reads, absorbs the one-cycle read latency in a
// 2-entry prefetch buffer and streams words downstream as valid/ready bursts with a last flag.
module fifo_rd_streamer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BeatW-1:0] BeatMax = BeatW'(BURST_LEN - 1);

  // Encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

  buf_state_e       state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pop;
  logic       capture;
  logic [1:0] occ_after_pop;

  // State register
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= StEmpty;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (capture) begin
          head_d  = fifo_rd_data;
          state_d = StOne;
        end
      end
      StOne: begin
        case ({capture, pop})
          2'b11: head_d = fifo_rd_data;
          2'b10: begin
            tail_d  = fifo_rd_data;
            state_d = StTwo;
          end
          2'b01: state_d = StEmpty;
          default: ;
        endcase
      end
      StTwo: begin
        if (pop) begin
          head_d = tail_q;
          if (capture) tail_d = fifo_rd_data;
          else state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    inflight_d = fifo_rd_en && !fifo_empty;
    beat_d     = beat_q;
    if (pop) beat_d = (beat_q == BeatMax) ? '0 : beat_q + BeatW'(1);
    cnt_d = cnt_q + CNT_W'(pop);
  end

  // Outputs
  always_comb begin
    out_valid     = !rd_rst && (state_q != StEmpty);
    pop           = out_valid && out_ready;
    capture       = inflight_q;
    // Occupancy after this cycle's pop; a read may issue only if a slot will be free.
    occ_after_pop = 2'(state_q) + 2'(inflight_q) - 2'(pop);
    fifo_rd_en    = !rd_rst && enable && !fifo_empty && (occ_after_pop < 2'd2);
    out_last      = out_valid && (beat_q == BeatMax);
    out_data      = head_q;
    word_count    = cnt_q;
  end

  overflow_a: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(capture && (state_q == StTwo) && !pop))
    else $error("prefetch buffer overflow");

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Self-checking bench: a queue-based FIFO model feeds the streamer and a scoreboard of
// accepted-but-undelivered words predicts the output order, framing and count.
module tb_fifo_rd_streamer;

  localparam int unsigned Width    = 8;
  localparam int unsigned BurstLen = 4;
  localparam int unsigned CntW     = 16;

  logic             clk = 1'b0;
  logic             rd_rst, enable, fifo_empty, out_ready;
  logic [Width-1:0] fifo_rd_data;
  logic             fifo_rd_en, out_valid, out_last;
  logic [Width-1:0] out_data;
  logic [CntW-1:0]  word_count;
  logic             rd_en1, valid1, last1;
  logic [Width-1:0] data1;
  logic [CntW-1:0]  count1;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.WIDTH(Width), .BURST_LEN(BurstLen), .CNT_W(CntW)) u_dut (
    .rd_clk      (clk),
    .rd_rst      (rd_rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .word_count  (word_count)
  );

  // Single-word bursts: last must track valid exactly.
  fifo_rd_streamer #(.WIDTH(Width), .BURST_LEN(1), .CNT_W(CntW)) u_dut_b1 (
    .rd_clk      (clk),
    .rd_rst      (rd_rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (rd_en1),
    .fifo_rd_data(fifo_rd_data),
    .out_valid   (valid1),
    .out_ready   (out_ready),
    .out_data    (data1),
    .out_last    (last1),
    .word_count  (count1)
  );

  logic [Width-1:0] mem[$];    // words still in the FIFO
  logic [Width-1:0] exp_q[$];  // words read from the FIFO, not yet delivered
  int n_checks = 0;
  int n_errors = 0;
  int n_words  = 0;
  int acc_cnt  = 0;
  int pop_cnt  = 0;
  int last_cnt = 0;
  logic stall_q = 1'b0;
  logic [Width-1:0] held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, req, $time);
    end
  endtask

  task automatic push(input logic [Width-1:0] w);
    mem.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Called in the low clock phase: samples just before the rising edge, updates models after it.
  task automatic step();
    logic acc, pop, last_s;
    logic [Width-1:0] w;
    #(4 - int'($time % 10));
    check("rd_en_while_empty", {31'b0, fifo_rd_en && fifo_empty}, 0);
    check("occupancy_le2", {31'b0, exp_q.size() <= 2}, 1);
    check("b1_last_eq_valid", {31'b0, last1}, {31'b0, valid1});
    if (rd_rst) check("reset_quiet", {29'b0, out_valid, out_last, fifo_rd_en}, 0);
    if (stall_q && out_valid) check("held_data", {24'b0, out_data}, {24'b0, held});
    pop    = out_valid && out_ready;
    last_s = out_last;
    if (pop) begin
      if (exp_q.size() == 0) check("spurious_word", {31'b0, out_valid}, 0);
      else begin
        check("data_order", {24'b0, out_data}, {24'b0, exp_q[0]});
        check("last_flag", {31'b0, out_last}, {31'b0, (n_words % BurstLen) == BurstLen - 1});
        check("word_count", {16'b0, word_count}, n_words & 32'hffff);
      end
    end
    acc     = fifo_rd_en && !fifo_empty;
    stall_q = out_valid && !out_ready;
    held    = out_data;
    @(posedge clk);
    if (rd_rst) begin
      exp_q.delete();
      n_words = 0;
    end else if (pop) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      n_words++;
      pop_cnt++;
      if (last_s) last_cnt++;
    end
    if (acc && mem.size() > 0) begin
      w = mem.pop_front();
      fifo_rd_data <= w;
      exp_q.push_back(w);
      acc_cnt++;
    end
    fifo_empty <= (mem.size() == 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
  endtask

  initial begin
    int budget;
    rd_rst       = 1'b1;
    enable       = 1'b1;
    out_ready    = 1'b1;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    @(negedge clk);
    step();
    step();
    rd_rst = 1'b0;
    check("rst_word_count", {16'b0, word_count}, 0);
    check("rst_out_data", {24'b0, out_data}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    step();

    // Basic order and latency
    push(8'h11);
    push(8'h22);
    push(8'h33);
    #1;
    check("lat_rd_en_n", {31'b0, fifo_rd_en}, 1);
    step();
    check("lat_valid_n1", {31'b0, out_valid}, 0);
    step();
    check("lat_valid_n2", {31'b0, out_valid}, 1);
    check("lat_data_n2", {24'b0, out_data}, 32'h11);
    repeat (6) step();
    check("basic_count", {16'b0, word_count}, 3);

    // Framing over 10 words
    do_reset();
    last_cnt = 0;
    for (int i = 0; i < 10; i++) push(Width'(8'h40 + i));
    repeat (16) step();
    check("frame_count", {16'b0, word_count}, 10);
    check("frame_lasts", last_cnt, 2);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int i = 0; i < 5; i++) push(Width'($urandom));
    repeat (6) step();
    check("bp_reads", acc_cnt, 2);
    check("bp_rd_en_low", {31'b0, fifo_rd_en}, 0);
    check("bp_valid", {31'b0, out_valid}, 1);
    out_ready = 1'b1;
    pop_cnt   = 0;
    repeat (5) step();
    check("bp_no_gaps", pop_cnt, 5);
    repeat (4) step();

    // Sustained 1 word/cycle
    do_reset();
    for (int i = 0; i < 8; i++) push(Width'($urandom));
    step();
    step();
    pop_cnt = 0;
    repeat (8) step();
    check("sustain_rate", pop_cnt, 8);
    repeat (4) step();

    // Enable gating with one buffered and one in flight
    do_reset();
    for (int i = 0; i < 8; i++) push(Width'($urandom));
    step();
    step();
    enable  = 1'b0;
    pop_cnt = 0;
    repeat (6) step();
    check("en_drain_pops", pop_cnt, 2);
    check("en_valid_low", {31'b0, out_valid}, 0);
    check("en_fifo_nonempty", {31'b0, fifo_empty}, 0);
    enable = 1'b1;
    repeat (12) step();

    // Reset mid-stream with a word in flight
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(Width'(8'ha0 + i));
    step();
    step();
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    check("mid_rst_valid", {31'b0, out_valid}, 0);
    check("mid_rst_count", {16'b0, word_count}, 0);
    out_ready = 1'b1;
    repeat (10) step();
    check("post_rst_count", {16'b0, word_count}, 2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (mem.size() < 12 && $urandom_range(0, 1) == 1) push(Width'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      rd_rst    = ($urandom_range(0, 199) == 0);
      step();
    end
    rd_rst    = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    budget    = 0;
    while ((mem.size() != 0 || exp_q.size() != 0) && budget < 100) begin
      step();
      budget++;
    end
    check("final_drain", mem.size() + exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
